// File: rtl/display_pkg.sv
// Shared constants for the counter/display slice: digit width and the
// active-high 7-segment glyph table ({g,f,e,d,c,b,a}) for hex digits 0-F.
package display_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Packed with digit F in the top slot so SEG_TABLE[n] is the glyph for n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Digit-word / display-pin bundle between the counter datapath (master)
// and the display scanner (slave).
interface bcd_display_scanner_if
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_in;
  logic [NUM_DIGITS-1:0]              dp_in;
  logic                               load;
  logic                               blank_lz;
  logic [6:0]                         seg;
  logic                               dp;
  logic [NUM_DIGITS-1:0]              an;
  logic                               frame_done;

  modport master (
    output digits_in, dp_in, load, blank_lz,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  digits_in, dp_in, load, blank_lz,
    output seg, dp, an, frame_done
  );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational 4-bit to 7-segment decoder with blanking; output is in
// pin polarity so counter top-levels can drive segment pins directly.
module hex_to_seg
  import display_pkg::*;
#(
  parameter int unsigned SEG_ACTIVE_LOW = 1
) (
  input  logic [DIGIT_W-1:0] hex,
  input  logic               blank,
  output logic [6:0]         seg
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = blank ? SEG_OFF : SEG_TABLE[hex];
    seg    = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Double-buffered, time-multiplexed 7-segment scanner: latches a digit word
// on load, swaps it in at frame boundaries, and lights one digit at a time.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 50_000,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  bcd_display_scanner_if.slave   bus
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  logic [PW-1:0] prescaler;
  logic [IW-1:0] idx;
  logic          tick;
  logic          wrap;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] staging;
  logic [NUM_DIGITS-1:0]              staging_dp;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] shadow;
  logic [NUM_DIGITS-1:0]              shadow_dp;
  logic                               pending;

  logic [DIGIT_W-1:0]    cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] lz;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] onehot;
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;

  logic [6:0]            seg_q;
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  frame_done_q;

  assign tick = (prescaler == PRE_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // The load update comes after the swap so a load on the wrap edge
  // re-arms pending for the next frame instead of being cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staging    <= '0;
      staging_dp <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
    end else begin
      if (wrap && pending) begin
        shadow    <= staging;
        shadow_dp <= staging_dp;
        pending   <= 1'b0;
      end
      if (bus.load) begin
        staging    <= bus.digits_in;
        staging_dp <= bus.dp_in;
        pending    <= 1'b1;
      end
    end
  end

  // lz[i]: digits i..NUM_DIGITS-1 of the shown word are all zero.
  always_comb begin
    all_zero = 1'b1;
    lz       = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      all_zero = all_zero & (shadow[NUM_DIGITS-1-k] == '0);
      lz[NUM_DIGITS-1-k] = all_zero;
    end
    lz[0] = 1'b0;
  end

  always_comb begin
    cur_digit   = shadow[idx];
    cur_blank   = bus.blank_lz & lz[idx];
    onehot      = '0;
    onehot[idx] = 1'b1;
    an_next     = (AN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    dp_next     = shadow_dp[idx] ^ DP_IDLE;
  end

  hex_to_seg #(
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .hex   (cur_digit),
    .blank (cur_blank),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= seg_next;
      dp_q         <= dp_next;
      an_q         <= an_next;
      frame_done_q <= wrap;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (4 digits, divide-by-4, active-low pins).
module tb_bcd_display_scanner;

  localparam int unsigned ND = 4;
  localparam int unsigned RD = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         pos;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  bcd_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [6:0] seg_al(input logic [3:0] d);
    case (d)
      4'h0: seg_al = 7'b1000000;
      4'h1: seg_al = 7'b1111001;
      4'h2: seg_al = 7'b0100100;
      4'h3: seg_al = 7'b0110000;
      4'h4: seg_al = 7'b0011001;
      4'h5: seg_al = 7'b0010010;
      4'h6: seg_al = 7'b0000010;
      4'h7: seg_al = 7'b1111000;
      4'h8: seg_al = 7'b0000000;
      4'h9: seg_al = 7'b0010000;
      4'hA: seg_al = 7'b0001000;
      4'hB: seg_al = 7'b0000011;
      4'hC: seg_al = 7'b1000110;
      4'hD: seg_al = 7'b0100001;
      4'hE: seg_al = 7'b0000110;
      default: seg_al = 7'b0001110;
    endcase
  endfunction

  task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv, input logic blz);
    logic [3:0] blank_m;
    logic       seen;
    exp_t       e;
    seen = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (d[4*i +: 4] != 4'h0) seen = 1'b1;
      blank_m[i] = blz && !seen && (i > 0);
    end
    for (int i = 0; i < 4; i++) begin
      e.an  = ~(4'b0001 << i);
      e.seg = blank_m[i] ? 7'h7F : seg_al(d[4*i +: 4]);
      e.dp  = ~dpv[i];
      e.pos = i;
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    logic [3:0] prev_an;
    exp_t       e;
    prev_an = 4'hF;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.an !== prev_an && sb.size() > 0) begin
        e = sb.pop_front();
        tests_run++;
        if (bus.an !== e.an || bus.seg !== e.seg || bus.dp !== e.dp) begin
          tests_failed++;
          $display("FAIL scan_digit%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   e.pos, bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
        end
      end
      prev_an = bus.an;
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 64);
    if (bus.frame_done !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL frame_timeout: frame_done=%b after %0d cycles, expected 1", bus.frame_done, n);
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] dpv);
    bus.digits_in = d;
    bus.dp_in     = dpv;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    reset         = 1'b0;
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.dp_in     = '0;
    bus.blank_lz  = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (bus.an !== 4'b1111) begin
      tests_failed++; $display("FAIL reset_an: got %b, expected 1111", bus.an);
    end
    tests_run++;
    if (bus.seg !== 7'b1111111) begin
      tests_failed++; $display("FAIL reset_seg: got %b, expected 1111111", bus.seg);
    end
    tests_run++;
    if (bus.dp !== 1'b1) begin
      tests_failed++; $display("FAIL reset_dp: got %b, expected 1", bus.dp);
    end
    tests_run++;
    if (bus.frame_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_frame_done: got %b, expected 0", bus.frame_done);
    end
    push_frame(16'h0000, 4'b0000, 1'b0);
    reset = 1'b1;
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL reset_frame0: %0d digits not shown, expected 0", sb.size());
    end
    @(negedge clk);
    tests_run++;
    if (bus.frame_done !== 1'b0) begin
      tests_failed++; $display("FAIL frame_done_width: got %b one cycle later, expected 0", bus.frame_done);
    end
    cnt = 1;
    while (bus.frame_done !== 1'b1 && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    tests_run++;
    if (cnt != 16) begin
      tests_failed++; $display("FAIL frame_period: got %0d cycles, expected 16", cnt);
    end
  endtask

  task automatic test_load();
    wait_frame();
    push_frame(16'h0000, 4'b0000, 1'b0);
    repeat (5) @(negedge clk);
    drive_load(16'h1234, 4'b0100);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL load_hold_old: %0d digits not shown, expected 0", sb.size());
    end
    push_frame(16'h1234, 4'b0100, 1'b0);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL load_new_frame: %0d digits not shown, expected 0", sb.size());
    end
  endtask

  task automatic test_blank();
    wait_frame();
    bus.blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    drive_load(16'h0007, 4'b0000);
    wait_frame();
    push_frame(16'h0007, 4'b0000, 1'b1);
    repeat (2) @(negedge clk);
    drive_load(16'h0000, 4'b0000);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL blank_0007: %0d digits not shown, expected 0", sb.size());
    end
    push_frame(16'h0000, 4'b0000, 1'b1);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL blank_0000: %0d digits not shown, expected 0", sb.size());
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    wait_frame();
    drive_load(16'h1111, 4'b0000);
    repeat (14) @(negedge clk);
    bus.digits_in = 16'h2222;
    bus.dp_in     = 4'b0000;
    bus.load      = 1'b1;
    @(negedge clk);
    bus.load      = 1'b0;
    tests_run++;
    if (bus.frame_done !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_on_wrap: frame_done=%b, expected 1", bus.frame_done);
    end
    push_frame(16'h1111, 4'b0000, 1'b0);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL b2b_frame1: %0d digits not shown, expected 0", sb.size());
    end
    push_frame(16'h2222, 4'b0000, 1'b0);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL b2b_frame2: %0d digits not shown, expected 0", sb.size());
    end
  endtask

  task automatic test_hex();
    wait_frame();
    drive_load(16'hFACE, 4'b1001);
    wait_frame();
    push_frame(16'hFACE, 4'b1001, 1'b0);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL hex_face: %0d digits not shown, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_midframe();
    wait_frame();
    repeat (3) @(negedge clk);
    drive_load(16'h5555, 4'b1111);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus.an !== 4'b1111) begin
      tests_failed++; $display("FAIL midreset_an: got %b, expected 1111", bus.an);
    end
    tests_run++;
    if (bus.seg !== 7'b1111111 || bus.dp !== 1'b1) begin
      tests_failed++; $display("FAIL midreset_seg: got seg=%b dp=%b, expected 1111111/1", bus.seg, bus.dp);
    end
    repeat (2) @(negedge clk);
    push_frame(16'h0000, 4'b0000, 1'b0);
    reset = 1'b1;
    wait_frame();
    push_frame(16'h0000, 4'b0000, 1'b0);
    wait_frame();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++; $display("FAIL midreset_discard: %0d digits not shown, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_load();
    test_blank();
    test_back_to_back();
    test_hex();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Time-multiplexed 7-segment display driver that consumes the 4-bit digit values produced by the team's counters (0-9 counter, hex counters). It latches a packed multi-digit word on a load strobe and double-buffers it so the displayed frame never tears. It then scans the digits one at a time at a divided refresh rate, decoding each to segments (0-F), with optional leading-zero blanking. It sits between the counter datapath and the board's shared-segment/common-anode display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=2).
REFRESH_DIV, 50_000, clk cycles each digit is lit (>=2); 1 kHz digit rate at 50 MHz.
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low, 0 = active-high.
AN_ACTIVE_LOW, 1, 1 = an pins active-low, 0 = active-high.

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
digits_in  input  4*NUM_DIGITS  packed digits; digit i = digits_in[4i+3:4i]; digit 0 least significant.
dp_in  input  NUM_DIGITS  decimal point per digit; 1 = lit.
load  input  1  capture strobe for digits_in/dp_in; level-sampled each cycle.
blank_lz  input  1  1 = blank leading zeros.
seg  output  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
dp  output  1  decimal point, polarity per SEG_ACTIVE_LOW.
an  output  NUM_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
frame_done  output  1  one-cycle pulse per completed scan frame.

Behaviour:
- Reset (reset=0, async): prescaler=0, idx=0, staging=0, shadow=0, pending=0, an=all inactive, seg=all off, dp=off, frame_done=0.
- Prescaler: width $clog2(REFRESH_DIV). Counts 0..REFRESH_DIV-1. tick=1 when prescaler==REFRESH_DIV-1; on that edge prescaler->0.
- Digit index: width max(1,$clog2(NUM_DIGITS)). Increments on tick, wraps NUM_DIGITS-1 -> 0. wrap = tick && idx==NUM_DIGITS-1.
- Load path: load=1 at an edge -> staging<=digits_in/dp_in, pending<=1. A repeat load while pending overwrites staging (latest wins).
- Frame boundary: on the wrap edge, if pending was 1 before that edge, shadow<=staging and pending<=0.
- Load coincident with wrap: the old staging goes to shadow. The new value goes to staging with pending=1 and is shown next frame. It is never lost.
- frame_done: registered; high exactly one cycle, in the cycle after the wrap edge.
- Outputs registered from (idx, shadow, blank_lz). They change one cycle after idx/shadow change. First valid digit appears one edge after reset release: an selects digit 0 and shows shadow digit 0 (=0 -> "0").
- Decode: 0-9 standard; 10-15 -> A,b,C,d,E,F. Active-high codes 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001. Invert when SEG_ACTIVE_LOW.
- Leading-zero blank: if blank_lz=1 and digit i>0 and digits i..NUM_DIGITS-1 of shadow are all 0, seg=all off for that digit; an still asserted; dp still follows dp_in. Digit 0 is never blanked.
- Exactly one an bit is active at any time after the first post-reset edge.
- Reset mid-frame: returns immediately to reset values; any pending load is discarded.

Decomposition:
- Shared package (display_pkg): the 16-entry active-high segment constant table, SEG_OFF constant, and digit width constant DIGIT_W=4.
- One sub-module: hex_to_seg, a combinational 4-bit to 7-segment decoder with blank input and SEG_ACTIVE_LOW parameter. Reusable by the other counter top-levels.

Test Plan:
(Benches use NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low.)
- Reset, hold reset=0 then release, no load -> an=1110, seg=1000000 ("0"); an rotates 1101,1011,0111,1110 every 4 cycles; frame_done pulses once per 16 cycles.
- load=1 one cycle with digits_in=16'h1234, dp_in=4'b0100 -> no change until next frame boundary. Then an=1110 shows seg=0011001 ("4"); digit 2 (an=1011) shows "2" with dp=0.
- Leading zeros: blank_lz=1, digits_in=16'h0007 -> digits 3,2,1 seg=1111111 with an still scanning; digit 0 shows "7" (1111000). With 16'h0000, digit 0 shows "0".
- Load coincident with wrap: load 16'h1111, then load 16'h2222 on the wrap edge -> frame N+1 shows 1111, frame N+2 shows 2222.
- Hex range: digits_in=16'hFACE -> digits 0..3 show E(0000110), C(1000110), A(0001000), F(0001110).
- Async reset mid-frame with a load pending -> outputs immediately an=1111 and seg=1111111. After release, display shows 0000 and the pending value is never shown.
